// File: rtl/mips_instr_encoder.sv
// MIPS instruction encoder: takes mnemonic-level requests and emits 32-bit
// instruction words with word-aligned addresses. A program runs from start to END.
module mips_instr_encoder (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        start,
  input  logic [31:0] start_addr,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_op,
  input  logic [4:0]  req_rs,
  input  logic [4:0]  req_rt,
  input  logic [4:0]  req_rd,
  input  logic [4:0]  req_shamt,
  input  logic [15:0] req_imm,
  input  logic [25:0] req_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  err_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    K_R = 2'd0,
    K_I = 2'd1,
    K_J = 2'd2
  } kind_t;

  localparam logic [4:0] OP_ILLEGAL = 5'd30;
  localparam logic [4:0] OP_END     = 5'd31;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] addr_q;
  logic        valid_q;
  logic        err_q;
  logic [7:0]  err_cnt_q;

  logic        accept_s;
  logic [31:0] instr_d;
  logic [31:0] pc_d;

  // Assembles one instruction word; field forcing zeroes the fields a format leaves unused.
  function automatic logic [31:0] encode(
    input logic [4:0]  op,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [4:0]  sh,
    input logic [15:0] imm,
    input logic [25:0] tgt
  );
    kind_t      kind;
    logic [5:0] code;
    logic [4:0] rs_f;
    logic [4:0] rt_f;
    logic [4:0] rd_f;
    logic [4:0] sh_f;
    logic [31:0] word;
    kind = K_R;
    code = 6'h00;
    rs_f = rs;
    rt_f = rt;
    rd_f = rd;
    sh_f = 5'd0;
    case (op)
      5'd0:  code = 6'h20;
      5'd1:  code = 6'h21;
      5'd2:  code = 6'h22;
      5'd3:  code = 6'h23;
      5'd4:  code = 6'h24;
      5'd5:  code = 6'h25;
      5'd6:  code = 6'h26;
      5'd7:  code = 6'h27;
      5'd8:  code = 6'h2A;
      5'd9:  begin code = 6'h00; rs_f = 5'd0; sh_f = sh; end
      5'd10: begin code = 6'h02; rs_f = 5'd0; sh_f = sh; end
      5'd11: begin code = 6'h03; rs_f = 5'd0; sh_f = sh; end
      5'd12: code = 6'h04;
      5'd13: code = 6'h06;
      5'd14: begin code = 6'h18; rd_f = 5'd0; end
      5'd15: begin code = 6'h1A; rd_f = 5'd0; end
      5'd16: begin code = 6'h08; rt_f = 5'd0; rd_f = 5'd0; end
      5'd17: begin kind = K_I; code = 6'h08; end
      5'd18: begin kind = K_I; code = 6'h09; end
      5'd19: begin kind = K_I; code = 6'h0C; end
      5'd20: begin kind = K_I; code = 6'h0D; end
      5'd21: begin kind = K_I; code = 6'h0E; end
      5'd22: begin kind = K_I; code = 6'h04; end
      5'd23: begin kind = K_I; code = 6'h05; end
      5'd24: begin kind = K_I; code = 6'h06; rt_f = 5'd0; end
      5'd25: begin kind = K_I; code = 6'h07; rt_f = 5'd0; end
      5'd26: begin kind = K_I; code = 6'h23; end
      5'd27: begin kind = K_I; code = 6'h2B; end
      5'd28: begin kind = K_J; code = 6'h02; end
      5'd29: begin kind = K_J; code = 6'h03; end
      default: begin kind = K_J; code = 6'h00; end
    endcase
    case (kind)
      K_R:     word = {6'h00, rs_f, rt_f, rd_f, sh_f, code};
      K_I:     word = {code, rs_f, rt_f, imm};
      K_J:     word = {code, tgt};
      default: word = 32'h0000_0000;
    endcase
    return word;
  endfunction

  assign req_ready = (state_q == S_RUN) && (!valid_q || out_ready);
  assign accept_s  = req_valid && req_ready;
  assign instr_d   = encode(req_op, req_rs, req_rt, req_rd, req_shamt, req_imm, req_target);
  assign pc_d      = pc_q + 32'd4;

  assign out_valid = valid_q;
  assign out_instr = instr_q;
  assign out_addr  = addr_q;
  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign err       = err_q;
  assign err_count = err_cnt_q;

  // Program framing FSM together with the one-entry output register.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q   <= S_IDLE;
      pc_q      <= 32'h0000_0000;
      instr_q   <= 32'h0000_0000;
      addr_q    <= 32'h0000_0000;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= 8'd0;
    end else begin
      if (valid_q && out_ready) begin
        valid_q <= 1'b0;
      end
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q   <= S_RUN;
            pc_q      <= start_addr & 32'hFFFF_FFFC;
            err_q     <= 1'b0;
            err_cnt_q <= 8'd0;
          end
        end
        S_RUN: begin
          if (accept_s) begin
            if (req_op == OP_END) begin
              state_q <= S_DONE;
            end else if (req_op == OP_ILLEGAL) begin
              err_q <= 1'b1;
              if (err_cnt_q != 8'hFF) begin
                err_cnt_q <= err_cnt_q + 8'd1;
              end
            end else begin
              instr_q <= instr_d;
              addr_q  <= pc_q;
              valid_q <= 1'b1;
              pc_q    <= pc_d;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Randomized scoreboard bench for mips_instr_encoder: stimulus pushes expected
// words, a monitor pops and compares whenever a word is handed off.
module tb_mips_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        start = 1'b0;
  logic [31:0] start_addr = 32'h0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [4:0]  req_op = 5'd0;
  logic [4:0]  req_rs = 5'd0;
  logic [4:0]  req_rt = 5'd0;
  logic [4:0]  req_rd = 5'd0;
  logic [4:0]  req_shamt = 5'd0;
  logic [15:0] req_imm = 16'h0;
  logic [25:0] req_target = 26'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        busy;
  logic        done;
  logic        err;
  logic [7:0]  err_count;

  mips_instr_encoder dut (
    .clk(clk), .rst_b(rst_b), .start(start), .start_addr(start_addr),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_shamt(req_shamt),
    .req_imm(req_imm), .req_target(req_target), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
    .busy(busy), .done(done), .err(err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
  } exp_t;

  localparam logic [5:0] R_FUNC [0:16] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
    6'h26, 6'h27, 6'h2A, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h18, 6'h1A, 6'h08};
  localparam logic [5:0] I_OPC [0:10] = '{6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h04,
    6'h05, 6'h06, 6'h07, 6'h23, 6'h2B};

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          ready_mode = 0;
  logic [31:0] m_addr = 32'h0;
  logic        m_err = 1'b0;
  int          m_err_cnt = 0;
  bit          m_run = 1'b0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  function automatic logic [31:0] ref_enc(input int op, input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [15:0] imm, input logic [25:0] tgt);
    bit shift_op;
    bit no_rd;
    shift_op = (op >= 9) && (op <= 11);
    no_rd = (op == 14) || (op == 15) || (op == 16);
    if (op <= 16)
      return {6'h00, shift_op ? 5'd0 : rs, (op == 16) ? 5'd0 : rt, no_rd ? 5'd0 : rd,
              shift_op ? sh : 5'd0, R_FUNC[op]};
    else if (op <= 27)
      return {I_OPC[op - 17], rs, ((op == 24) || (op == 25)) ? 5'd0 : rt, imm};
    else
      return {(op == 28) ? 6'h02 : 6'h03, tgt};
  endfunction

  // Downstream ready generator.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom % 4) != 0;
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: checks held words stay stable and pops the scoreboard on each handoff.
  initial begin
    logic        held;
    logic [31:0] held_i;
    logic [31:0] held_a;
    exp_t        e;
    held = 1'b0;
    held_i = 32'h0;
    held_a = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst_b) begin
        held = 1'b0;
      end else begin
        if (held) begin
          check32("hold_valid", 32'(out_valid), 32'd1);
          check32("hold_instr", out_instr, held_i);
          check32("hold_addr", out_addr, held_a);
        end
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_word: got %h @ %h, required no word", out_instr, out_addr);
          end else begin
            e = sb_q.pop_front();
            check32("word_instr", out_instr, e.instr);
            check32("word_addr", out_addr, e.addr);
          end
        end
        held = out_valid && !out_ready;
        held_i = out_instr;
        held_a = out_addr;
      end
    end
  end

  task automatic send(input int op, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                      input logic [4:0] sh, input logic [15:0] imm, input logic [25:0] tgt,
                      input bit directed, input logic [31:0] d_instr);
    int k;
    exp_t e;
    k = 0;
    req_op = 5'(op);
    req_rs = rs;
    req_rt = rt;
    req_rd = rd;
    req_shamt = sh;
    req_imm = imm;
    req_target = tgt;
    req_valid = 1'b1;
    @(negedge clk);
    while (!req_ready && k < 300) begin
      k++;
      @(negedge clk);
    end
    if (!req_ready) begin
      n_checks++;
      $display("FAIL accept_timeout: req_ready 0 for op %0d, required 1", op);
    end else if (op <= 29) begin
      e.instr = directed ? d_instr : ref_enc(op, rs, rt, rd, sh, imm, tgt);
      e.addr = m_addr;
      sb_q.push_back(e);
      m_addr = m_addr + 32'd4;
    end else if (op == 30) begin
      m_err = 1'b1;
      if (m_err_cnt < 255) m_err_cnt++;
    end else begin
      m_run = 1'b0;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic send_rand(input int lo, input int hi);
    send($urandom_range(hi, lo), 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
         16'($urandom), 26'($urandom), 1'b0, 32'h0);
  endtask

  task automatic do_start(input logic [31:0] a);
    start_addr = a;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (!m_run) begin
      m_run = 1'b1;
      m_addr = {a[31:2], 2'b00};
      m_err = 1'b0;
      m_err_cnt = 0;
    end
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while ((sb_q.size() != 0 || out_valid) && k < 500) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (sb_q.size() == 0 && !out_valid) n_pass++;
    else $display("FAIL drain_timeout: %0d words outstanding, required 0", sb_q.size());
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check32({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    check32({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check32({tag, "_out_instr"}, out_instr, 32'h0);
    check32({tag, "_out_addr"}, out_addr, 32'h0);
    check32({tag, "_busy"}, 32'(busy), 32'd0);
    check32({tag, "_done"}, 32'(done), 32'd0);
    check32({tag, "_err"}, 32'(err), 32'd0);
    check32({tag, "_err_count"}, 32'(err_count), 32'd0);
  endtask

  initial begin
    time t0;
    #12;
    check_reset("reset");
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    ready_mode = 0;
    @(posedge clk);
    #1;

    do_start(32'h0040_0003);
    check32("busy_after_start", 32'(busy), 32'd1);
    check32("done_after_start", 32'(done), 32'd0);
    send(0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b1, 32'h0022_1820);
    send(17, 5'd0, 5'd8, 5'd0, 5'd0, 16'h0005, 26'h0, 1'b1, 32'h2008_0005);
    send(9, 5'd7, 5'd1, 5'd2, 5'd4, 16'h0, 26'h0, 1'b1, 32'h0001_1100);
    send(26, 5'd29, 5'd9, 5'd0, 5'd0, 16'hFFFC, 26'h0, 1'b1, 32'h8FA9_FFFC);
    send(28, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h010_0000, 1'b1, 32'h0810_0000);

    // Backpressure: one word held for 5 cycles with a request waiting.
    ready_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    send_rand(0, 29);
    fork
      send_rand(0, 29);
      begin
        repeat (5) begin
          @(negedge clk);
          check32("bp_req_ready", 32'(req_ready), 32'd0);
          check32("bp_out_valid", 32'(out_valid), 32'd1);
        end
        ready_mode = 0;
      end
    join
    t0 = $time;
    repeat (8) send_rand(0, 29);
    check32("throughput_8_words", 32'($time - t0), 32'd80);
    wait_drain();

    do_start(32'h1234_5678);
    check32("start_in_run_busy", 32'(busy), 32'd1);
    ready_mode = 1;
    repeat (150) send_rand(0, 30);
    wait_drain();
    check32("rand_err", 32'(err), 32'(m_err));
    check32("rand_err_count", 32'(err_count), 32'(m_err_cnt));

    ready_mode = 0;
    send_rand(0, 29);
    send(31, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b0, 32'h0);
    check32("end_done", 32'(done), 32'd1);
    check32("end_busy", 32'(busy), 32'd0);
    check32("end_req_ready", 32'(req_ready), 32'd0);
    wait_drain();

    do_start(32'h0000_1000);
    ready_mode = 1;
    send(0, 5'd4, 5'd5, 5'd6, 5'd0, 16'h0, 26'h0, 1'b0, 32'h0);
    send(30, 5'd1, 5'd1, 5'd1, 5'd1, 16'h1, 26'h1, 1'b0, 32'h0);
    send(20, 5'd3, 5'd4, 5'd0, 5'd0, 16'hBEEF, 26'h0, 1'b0, 32'h0);
    send(30, 5'd2, 5'd2, 5'd2, 5'd2, 16'h2, 26'h2, 1'b0, 32'h0);
    send(6, 5'd9, 5'd10, 5'd11, 5'd12, 16'h0, 26'h0, 1'b0, 32'h0);
    wait_drain();
    check32("illegal_err", 32'(err), 32'd1);
    check32("illegal_err_count", 32'(err_count), 32'd2);
    send(31, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b0, 32'h0);

    do_start(32'hFFFF_FFF8);
    check32("restart_err", 32'(err), 32'd0);
    check32("restart_err_count", 32'(err_count), 32'd0);
    repeat (3) send_rand(0, 29);
    wait_drain();
    check32("wrap_next_addr_model", m_addr, 32'h0000_0004);

    ready_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    send_rand(0, 29);
    rst_b = 1'b0;
    #1;
    check_reset("midrun_reset");
    sb_q.delete();
    m_run = 1'b0;
    ready_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("held_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mips_instr_encoder.md
# mips_instr_encoder

Sequential MIPS instruction encoder: the write-side counterpart of the control-unit decode path. It accepts mnemonic-level requests (operation enum plus register/immediate fields) over a valid/ready handshake, assembles the 32-bit MIPS instruction word, and streams it with a word-aligned target address toward instruction memory or a program loader. A small state machine frames each program between `start` and an END request.

## Interface
- `clk`  input  1  system clock, all state on rising edge
- `rst_b`  input  1  asynchronous, active-low reset
- `start`  input  1  begin a program; sampled only in IDLE or DONE
- `start_addr`  input  32  first instruction address; bits [1:0] ignored
- `req_valid`  input  1  request present
- `req_ready`  output  1  request accepted this cycle when high with `req_valid`
- `req_op`  input  5  operation enum (see Operation)
- `req_rs`, `req_rt`, `req_rd`  input  5 each  register fields
- `req_shamt`  input  5  shift amount
- `req_imm`  input  16  I-type immediate
- `req_target`  input  26  J-type target
- `out_valid`  output  1  encoded word present
- `out_ready`  input  1  downstream accepts word
- `out_instr`  output  32  encoded instruction
- `out_addr`  output  32  address of `out_instr`
- `busy`  output  1  state is RUN
- `done`  output  1  state is DONE
- `err`  output  1  sticky illegal-op flag, cleared on `start`
- `err_count`  output  8  saturating illegal-op count, cleared on `start`

## Operation
- req_op enum: 0 ADD, 1 ADDU, 2 SUB, 3 SUBU, 4 AND, 5 OR, 6 XOR, 7 NOR, 8 SLT, 9 SLL, 10 SRL, 11 SRA, 12 SLLV, 13 SRLV, 14 MULT, 15 DIV, 16 JR, 17 ADDI, 18 ADDIU, 19 ANDI, 20 ORI, 21 XORI, 22 BEQ, 23 BNE, 24 BLEZ, 25 BGTZ, 26 LW, 27 SW, 28 J, 29 JAL, 30 illegal, 31 END.
- R-type (0–16): {6'h00, rs, rt, rd, shamt, func}. func values: ADD 20, ADDU 21, SUB 22, SUBU 23, AND 24, OR 25, XOR 26, NOR 27, SLT 2A, SLL 00, SRL 02, SRA 03, SLLV 04, SRLV 06, MULT 18, DIV 1A, JR 08 (hex).
- R-type field forcing:
  - SLL/SRL/SRA: rs field = 0.
  - JR: rt, rd and shamt = 0.
  - MULT/DIV: rd and shamt = 0.
  - All other R-type: shamt = 0.
- I-type: {op, rs, rt, imm}. Opcodes: ADDI 08, ADDIU 09, ANDI 0C, ORI 0D, XORI 0E, BEQ 04, BNE 05, BLEZ 06, BGTZ 07, LW 23, SW 2B. BLEZ/BGTZ force rt = 0.
- J-type: {op, target}. Opcodes: J 02, JAL 03.
- FSM states are IDLE, RUN and DONE.
  - IDLE, `start`: go to RUN; load `out_addr` base = {start_addr[31:2], 2'b00}; clear `err`/`err_count`.
  - RUN, accepted valid op (0–29): word written to the output register at the current address. The address counter then advances by 4, wrapping from FFFFFFFC to 0.
  - RUN, accepted op 30: no word emitted; counter unchanged; `err` set; `err_count` incremented, saturating at 255.
  - RUN, accepted END: no word emitted; go to DONE.
  - DONE, `start`: restart exactly as from IDLE.
  - `start` during RUN is ignored.
- Output register holds one entry. `out_valid` stays high and `out_instr`/`out_addr` stay stable until `out_ready`.
- END handling: once END is accepted, a word still pending in the output register drains normally while in DONE.

## Timing
- Reset values (asynchronous): state IDLE, `req_ready` 0, `out_valid` 0, `out_instr` 0, `out_addr` 0, `busy` 0, `done` 0, `err` 0, `err_count` 0.
- Ready rule: `req_ready` = (state == RUN) && (!`out_valid` || `out_ready`). It is combinational from state and `out_ready`, giving a full-throughput pass-through.
- Latency: a request accepted in cycle N produces `out_valid` in N+1.
- Back-to-back requests with `out_ready` held high sustain 1 word/cycle.
- When `out_valid` && `out_ready` occur in the same cycle as a new accept, the register is replaced with the new word and `out_valid` stays high.
- When `out_valid` && `out_ready` occur with no accept (or with an accepted illegal/END op), `out_valid` drops the next cycle.
- `start` takes effect on the clock edge where it is sampled. `busy` rises the next cycle, and the first request can be accepted in that cycle.
- Reset asserted mid-RUN aborts immediately and drops any pending word.

## Test plan
- Start with `start_addr`=00400003, then ADD rs=1 rt=2 rd=3 -> `out_instr`=00221820, `out_addr`=00400000. Next ADDI rs=0 rt=8 imm=0005 -> 20080005 @ 00400004.
- SLL rs=7 rt=1 rd=2 shamt=4 -> 00011100 (rs forced 0). LW rs=29 rt=9 imm=FFFC -> 8FA9FFFC. J target=0100000 -> 08100000.
- Hold `out_ready` low for 5 cycles with `req_valid` high -> exactly one word held stable, `req_ready` low, no address advance. Release -> one word/cycle thereafter.
- Op 30 sent twice between valid ops -> `err`=1, `err_count`=2, no output words for them, addresses contiguous. Then `start` -> both cleared.
- `start_addr`=FFFFFFF8 with 3 ops -> addresses FFFFFFF8, FFFFFFFC, 00000000.
- END while an output word is pending -> word drains, `done`=1, `req_ready`=0. `start` in RUN is ignored. `rst_b` low mid-stream -> all outputs return to reset values immediately.
